// File: rtl/rolling_perf_pkg.sv
// rolling_perf_pkg: shared FSM state, drained-point record and saturating add for the rolling perf sampler
package rolling_perf_pkg;

    typedef enum logic {IDLE, DRAIN} rp_state_e;

    typedef struct packed {
        logic [63:0] y;
        logic [63:0] x;
        logic [63:0] stamp;
    } rp_point_t;

    // Unsigned add of a and b that clamps at 2^w-1; w may be 1..64.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int unsigned w);
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (65'd1 << w) - 65'd1;
        return (s > m) ? m[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/rolling_perf_sampler_if.sv
// rolling_perf_sampler_if: perf-event taps in, rolling writer port out
//   master: drives perf_en/ev_inc, observes wr_*/overrun
//   slave : the sampler side
interface rolling_perf_sampler_if #(
    parameter int NUM_SRC = 4,
    parameter int INC_W   = 4,
    parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
    logic                     perf_en;
    logic [NUM_SRC*INC_W-1:0] ev_inc;
    logic                     wr_en;
    logic [63:0]              wr_yAxisPt;
    logic [63:0]              wr_xAxisPt;
    logic [63:0]              wr_stamp;
    logic [SRC_W-1:0]         wr_src;
    logic                     overrun;

    modport master (
        output perf_en, ev_inc,
        input  wr_en, wr_yAxisPt, wr_xAxisPt, wr_stamp, wr_src, overrun
    );

    modport slave (
        input  perf_en, ev_inc,
        output wr_en, wr_yAxisPt, wr_xAxisPt, wr_stamp, wr_src, overrun
    );
endinterface

// File: rtl/rolling_perf_acc.sv
// rolling_perf_acc: one source's saturating accumulator with clear-and-snapshot at window end
//   clk_i/rst_i : clock, sync active-high reset
//   en_i        : accumulate enable (perf_en)
//   clr_i       : window end; the end-cycle increment lands in the snapshot, acc restarts at 0
//   inc_i       : per-cycle increment
//   snap_o      : count of the last closed window
module rolling_perf_acc
    import rolling_perf_pkg::*;
#(
    parameter int INC_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [INC_W-1:0] inc_i,
    output logic [CNT_W-1:0] snap_o
);
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] snap_q;
    logic [CNT_W-1:0] sum;

    assign sum    = CNT_W'(sat_add(64'(acc_q), 64'(inc_i), CNT_W));
    assign snap_o = snap_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else if (en_i) begin
            acc_q <= clr_i ? '0 : sum;
            if (clr_i) snap_q <= sum;
        end
    end
endmodule

// File: rtl/rolling_perf_sampler.sv
// rolling_perf_sampler: windowed per-source event counts drained one source per cycle into a rolling writer port
//   clock/reset : clock, sync active-high reset
//   bus (slave) : perf_en/ev_inc in; wr_en/wr_yAxisPt/wr_xAxisPt/wr_stamp/wr_src/overrun out
//   WIN_CHECK   : 0 lifts the WINDOW >= NUM_SRC+1 elaboration check
//   ROLLING_PERF_SKIP_ZERO_EN : when defined, zero-count slots stay silent (drain timing unchanged)
module rolling_perf_sampler
    import rolling_perf_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int INC_W     = 4,
    parameter int CNT_W     = 32,
    parameter int WINDOW    = 1000,
    parameter bit WIN_CHECK = 1'b1
) (
    input logic                  clock,
    input logic                  reset,
    rolling_perf_sampler_if.slave bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    if (WIN_CHECK && WINDOW < NUM_SRC + 1) begin : g_win_chk
        $error("rolling_perf_sampler: WINDOW must be >= NUM_SRC+1");
    end

    rp_state_e        state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [WIN_W-1:0] win_cnt_q;
    logic [63:0]      win_idx_q, snap_idx_q, cyc_cnt_q;
    logic             overrun_q;
    logic             win_end, emit;
    logic [CNT_W-1:0] snap [NUM_SRC];
    rp_point_t        pt;

    assign win_end = bus.perf_en && win_cnt_q == WIN_W'(WINDOW - 1);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_acc
        rolling_perf_acc #(.INC_W(INC_W), .CNT_W(CNT_W)) u_acc (
            .clk_i  (clock),
            .rst_i  (reset),
            .en_i   (bus.perf_en),
            .clr_i  (win_end),
            .inc_i  (bus.ev_inc[i*INC_W +: INC_W]),
            .snap_o (snap[i])
        );
    end

    // A window end always (re)starts the drain at source 0, aborting any drain in progress.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == DRAIN) begin
            ptr_d   = ptr_q + SRC_W'(1);
            state_d = (ptr_q == SRC_W'(NUM_SRC - 1)) ? IDLE : DRAIN;
        end
        if (win_end) begin
            state_d = DRAIN;
            ptr_d   = '0;
        end
    end

`ifdef ROLLING_PERF_SKIP_ZERO_EN
    assign emit = state_q == DRAIN && snap[ptr_q] != '0;
`else
    assign emit = state_q == DRAIN;
`endif

    assign pt             = emit ? '{y: 64'(snap[ptr_q]), x: snap_idx_q, stamp: cyc_cnt_q} : '0;
    assign bus.wr_en      = emit;
    assign bus.wr_src     = emit ? ptr_q : '0;
    assign bus.wr_yAxisPt = pt.y;
    assign bus.wr_xAxisPt = pt.x;
    assign bus.wr_stamp   = pt.stamp;
    assign bus.overrun    = overrun_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_cnt_q  <= '0;
            win_idx_q  <= '0;
            snap_idx_q <= '0;
            cyc_cnt_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cyc_cnt_q <= cyc_cnt_q + 64'd1;
            if (bus.perf_en) win_cnt_q <= win_end ? '0 : win_cnt_q + WIN_W'(1);
            if (win_end) begin
                snap_idx_q <= win_idx_q;
                win_idx_q  <= win_idx_q + 64'd1;
            end
            if (win_end && state_q == DRAIN) overrun_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rolling_perf_sampler.sv
// tb_rolling_perf_sampler: directed checks of window counting, drain, masking, saturation, reset and overrun
module tb_rolling_perf_sampler;
    import rolling_perf_pkg::*;

`ifdef ROLLING_PERF_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        perf_en = 1'b0;
    logic [15:0] ev = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rolling_perf_sampler_if #(.NUM_SRC(4), .INC_W(4)) m_if ();
    rolling_perf_sampler_if #(.NUM_SRC(4), .INC_W(4)) s_if ();
    rolling_perf_sampler_if #(.NUM_SRC(4), .INC_W(4)) o_if ();

    assign m_if.perf_en = perf_en;
    assign m_if.ev_inc  = ev;
    assign s_if.perf_en = perf_en;
    assign s_if.ev_inc  = ev;
    assign o_if.perf_en = perf_en;
    assign o_if.ev_inc  = ev;

    rolling_perf_sampler #(.NUM_SRC(4), .INC_W(4), .CNT_W(8), .WINDOW(16)) u_main (
        .clock (clk), .reset (rst), .bus (m_if)
    );
    rolling_perf_sampler #(.NUM_SRC(4), .INC_W(4), .CNT_W(7), .WINDOW(16)) u_sat (
        .clock (clk), .reset (rst), .bus (s_if)
    );
    rolling_perf_sampler #(.NUM_SRC(4), .INC_W(4), .CNT_W(8), .WINDOW(3), .WIN_CHECK(1'b0)) u_ov (
        .clock (clk), .reset (rst), .bus (o_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic main_pt(input string tag, input logic en, input int src, input longint y, input longint x, input longint st);
        check({tag, "_en"}, 64'(m_if.wr_en), 64'(en));
        check({tag, "_src"}, 64'(m_if.wr_src), en ? 64'(src) : 64'd0);
        check({tag, "_y"}, m_if.wr_yAxisPt, en ? 64'(y) : 64'd0);
        check({tag, "_x"}, m_if.wr_xAxisPt, en ? 64'(x) : 64'd0);
        check({tag, "_stamp"}, m_if.wr_stamp, en ? 64'(st) : 64'd0);
    endtask

    initial begin
        tick(2);
        check("rst_en", 64'(m_if.wr_en), 64'd0);
        check("rst_y", m_if.wr_yAxisPt, 64'd0);
        check("rst_stamp", m_if.wr_stamp, 64'd0);
        check("rst_ovr", 64'(m_if.overrun), 64'd0);
        rst = 1'b0;
        perf_en = 1'b1;
        ev = 16'h0321;
        tick(16);
        main_pt("w0s0", 1'b1, 0, 16, 0, 16);
        check("sat_w0s0", s_if.wr_yAxisPt, 64'd16);
        tick(1);
        main_pt("w0s1", 1'b1, 1, 32, 0, 17);
        tick(1);
        main_pt("w0s2", 1'b1, 2, 48, 0, 18);
        tick(1);
        main_pt("w0s3", !SKIP, 3, 0, 0, 19);
        tick(1);
        main_pt("idle", 1'b0, 0, 0, 0, 0);
        perf_en = 1'b0;
        ev = 16'hFFFF;
        tick(5);
        perf_en = 1'b1;
        ev = 16'h0321;
        tick(7);
        check("mask_no_early", 64'(m_if.wr_en), 64'd0);
        tick(5);
        main_pt("w1s0", 1'b1, 0, 16, 1, 37);
        ev = 16'h000F;
        tick(1);
        main_pt("w1s1", 1'b1, 1, 32, 1, 38);
        tick(15);
        main_pt("w2s0", 1'b1, 0, 240, 2, 53);
        check("sat_w2s0", s_if.wr_yAxisPt, 64'd127);
        check("sat_w2x", s_if.wr_xAxisPt, 64'd2);
        tick(16);
        main_pt("w3s0", 1'b1, 0, 240, 3, 69);
        check("main_ovr", 64'(m_if.overrun), 64'd0);
        tick(1);
        check("w3s1_en", 64'(m_if.wr_en), 64'(!SKIP));
        rst = 1'b1;
        tick(1);
        check("rst_mid_en", 64'(m_if.wr_en), 64'd0);
        check("rst_mid_y", m_if.wr_yAxisPt, 64'd0);
        rst = 1'b0;
        ev = 16'h0321;
        tick(1);
        check("post_rst_en", 64'(m_if.wr_en), 64'd0);
        check("ov_cleared", 64'(o_if.overrun), 64'd0);
        tick(2);
        check("ov_d0_en", 64'(o_if.wr_en), 64'd1);
        check("ov_d0_y", o_if.wr_yAxisPt, 64'd3);
        check("ov_d0_x", o_if.wr_xAxisPt, 64'd0);
        tick(2);
        check("ov_d2_src", 64'(o_if.wr_src), 64'd2);
        check("ov_d2_y", o_if.wr_yAxisPt, 64'd9);
        check("ov_d2_ovr", 64'(o_if.overrun), 64'd0);
        tick(1);
        check("ov_rs_src", 64'(o_if.wr_src), 64'd0);
        check("ov_rs_x", o_if.wr_xAxisPt, 64'd1);
        check("ov_rs_y", o_if.wr_yAxisPt, 64'd3);
        check("ov_rs_ovr", 64'(o_if.overrun), 64'd1);
        tick(10);
        main_pt("r0s0", 1'b1, 0, 16, 0, 16);
        check("r0_ovr", 64'(m_if.overrun), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
